ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.

---
 rtl/ps2_host_tx.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter; only ever pulls the open-drain PS2C/PS2D lines low.
// Build macro PS2_TX_RESEND_EN: a failed ACK or a timeout triggers exactly one automatic retry of the latched frame.
module ps2_host_tx #(
   parameter int unsigned CLK_HZ         = 50_000_000,
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_error,
   input  logic       PS2C,
   input  logic       PS2D,
   output logic       ps2c_pull_low,
   output logic       ps2d_pull_low
);

   localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
   localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
   localparam logic             START_AT_ACCEPT = (INHIBIT_CYCLES == 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQ,
      ST_SHIFT,
      ST_ACK,
      ST_WAIT_IDLE
   } state_t;

   // CLK_HZ records the clock the cycle-count parameters were derived from.
   logic unused_clk_hz;
   assign unused_clk_hz = |CLK_HZ;

   logic [1:0]       ps2c_sync_q;
   logic [1:0]       ps2d_sync_q;
   logic             ps2c_prev_q;
   logic             ps2c_s;
   logic             ps2d_s;
   logic             fall;

   state_t           state_q;
   logic [9:0]       frame_q;
   logic [INH_W-1:0] inh_cnt_q;
   logic [TO_W-1:0]  to_cnt_q;
   logic [TO_W-1:0]  to_cnt_d;
   logic [3:0]       idx_q;
   logic             ack_ok_q;
   logic             tx_ready_q;
   logic             tx_done_q;
   logic             tx_error_q;
   logic             ps2c_pull_low_q;
   logic             ps2d_pull_low_q;
   logic             fail_timeout;
   logic             fail_nack;
   logic             retry_ok;

`ifdef PS2_TX_RESEND_EN
   logic             retry_q;
   assign retry_ok = !retry_q;
`else
   assign retry_ok = 1'b0;
`endif

   // Synchronisers reset to the idle (released) line level so reset never fakes a falling edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         ps2c_sync_q <= 2'b11;
         ps2d_sync_q <= 2'b11;
         ps2c_prev_q <= 1'b1;
      end else begin
         ps2c_sync_q <= {ps2c_sync_q[0], PS2C};
         ps2d_sync_q <= {ps2d_sync_q[0], PS2D};
         ps2c_prev_q <= ps2c_sync_q[1];
      end
   end

   assign ps2c_s = ps2c_sync_q[1];
   assign ps2d_s = ps2d_sync_q[1];
   assign fall   = ps2c_prev_q & ~ps2c_s;

   always_comb begin
      to_cnt_d     = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TO_W'(1);
      fail_timeout = (state_q inside {ST_REQ, ST_SHIFT, ST_ACK}) && (to_cnt_d == TO_MAX) &&
                     !(state_q == ST_ACK && fall);
      fail_nack    = (state_q == ST_WAIT_IDLE) && ps2c_s && ps2d_s && !ack_ok_q;
   end

   // NOTE: every assignment here is non-blocking, so a later assignment in the same edge
   // wins; the failure handling after the case relies on that to override the case arm.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         frame_q         <= '0;
         inh_cnt_q       <= '0;
         to_cnt_q        <= '0;
         idx_q           <= '0;
         ack_ok_q        <= 1'b0;
         tx_ready_q      <= 1'b1;
         tx_done_q       <= 1'b0;
         tx_error_q      <= 1'b0;
         ps2c_pull_low_q <= 1'b0;
         ps2d_pull_low_q <= 1'b0;
`ifdef PS2_TX_RESEND_EN
         retry_q         <= 1'b0;
`endif
      end else begin
         tx_done_q  <= 1'b0;
         tx_error_q <= 1'b0;

         unique case (state_q)
            ST_IDLE: begin
               if (tx_valid && tx_ready_q) begin
                  frame_q         <= {1'b1, ~^tx_data, tx_data};
                  inh_cnt_q       <= '0;
                  ps2c_pull_low_q <= 1'b1;
                  ps2d_pull_low_q <= START_AT_ACCEPT;
                  tx_ready_q      <= 1'b0;
                  state_q         <= ST_INHIBIT;
`ifdef PS2_TX_RESEND_EN
                  retry_q         <= 1'b0;
`endif
               end
            end

            ST_INHIBIT: begin
               inh_cnt_q <= inh_cnt_q + INH_W'(1);
               if (inh_cnt_q == INH_PRE) begin
                  ps2d_pull_low_q <= 1'b1;
               end
               if (inh_cnt_q == INH_LAST) begin
                  ps2c_pull_low_q <= 1'b0;
                  ps2d_pull_low_q <= 1'b1;
                  to_cnt_q        <= '0;
                  state_q         <= ST_REQ;
               end
            end

            ST_REQ: begin
               idx_q   <= '0;
               state_q <= ST_SHIFT;
            end

            // Data changes while the device holds the clock low; idx 9 is the always-1 stop bit.
            ST_SHIFT: begin
               if (fall) begin
                  ps2d_pull_low_q <= ~frame_q[idx_q];
                  idx_q           <= idx_q + 4'd1;
                  if (idx_q == 4'd9) begin
                     state_q <= ST_ACK;
                  end
               end
            end

            ST_ACK: begin
               if (fall) begin
                  ack_ok_q <= ~ps2d_s;
                  state_q  <= ST_WAIT_IDLE;
               end
            end

            ST_WAIT_IDLE: begin
               if (ps2c_s && ps2d_s && ack_ok_q) begin
                  tx_done_q  <= 1'b1;
                  tx_ready_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase

         if (state_q inside {ST_REQ, ST_SHIFT, ST_ACK}) begin
            to_cnt_q <= to_cnt_d;
         end

         if (fail_timeout || fail_nack) begin
            if (retry_ok) begin
               inh_cnt_q       <= '0;
               ps2c_pull_low_q <= 1'b1;
               ps2d_pull_low_q <= START_AT_ACCEPT;
               state_q         <= ST_INHIBIT;
`ifdef PS2_TX_RESEND_EN
               retry_q         <= 1'b1;
`endif
            end else begin
               ps2c_pull_low_q <= 1'b0;
               ps2d_pull_low_q <= 1'b0;
               tx_error_q      <= 1'b1;
               tx_ready_q      <= 1'b1;
               state_q         <= ST_IDLE;
            end
         end
      end
   end

   assign tx_ready      = tx_ready_q;
   assign tx_done       = tx_done_q;
   assign tx_error      = tx_error_q;
   assign ps2c_pull_low = ps2c_pull_low_q;
   assign ps2d_pull_low = ps2d_pull_low_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboarded bench with a PS/2 device model on an open-drain bus.
// Timing is scaled down (short inhibit, timeout and device clock period) to keep the run short.
module tb_ps2_host_tx;

   localparam int INH = 200;
   localparam int TO  = 3000;
   localparam int H   = 20;   // device clock half-period in system cycles
`ifdef PS2_TX_RESEND_EN
   localparam int ATTEMPTS = 2;
`else
   localparam int ATTEMPTS = 1;
`endif

   typedef struct packed {
      logic is_err;
      logic chk_to;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_error;
   logic       ps2c;
   logic       ps2d;
   logic       ps2c_pull_low;
   logic       ps2d_pull_low;

   logic dev_clk_low  = 1'b0;
   logic dev_data_low = 1'b0;
   logic dev_clocks   = 1'b1;
   logic dev_ack      = 1'b1;
   logic dev_skip     = 1'b0;
   logic dev_busy     = 1'b0;
   int   dev_bit      = -1;
   int   dev_low_cnt;
   int   dev_both_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int release_cyc   = 0;
   int frames_seen   = 0;
   int inhibits_seen = 0;
   int done_seen     = 0;

   exp_t       exp_q[$];
   logic [9:0] exp_frame_q[$];
   exp_t       mon_e;

   assign ps2c = ~(ps2c_pull_low | dev_clk_low);
   assign ps2d = ~(ps2d_pull_low | dev_data_low);

   ps2_host_tx #(
      .CLK_HZ        (50_000_000),
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .tx_done      (tx_done),
      .tx_error     (tx_error),
      .PS2C         (ps2c),
      .PS2D         (ps2d),
      .ps2c_pull_low(ps2c_pull_low),
      .ps2d_pull_low(ps2d_pull_low)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      repeat (80000) @(posedge clk);
      $display("FAIL watchdog: run exceeded cycle budget, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Device side of one frame: 10 clocks for d0..d7/parity/stop, then the ACK clock.
   task automatic run_frame();
      logic [9:0] bits;
      bits     = '0;
      dev_busy = 1'b1;
      repeat (H) @(negedge clk);
      check("start_bit", 32'(ps2d), 0);
      for (int i = 0; i < 10; i++) begin
         dev_bit     = i;
         dev_clk_low = 1'b1;
         repeat (H) @(negedge clk);
         bits[i]     = ps2d;
         dev_clk_low = 1'b0;
         repeat (H) @(negedge clk);
      end
      dev_bit      = 10;
      dev_data_low = dev_ack;
      dev_clk_low  = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low  = 1'b0;
      repeat (H) @(negedge clk);
      dev_data_low = 1'b0;
      frames_seen++;
      if (dev_skip) begin
         dev_skip = 1'b0;
      end else if (exp_frame_q.size() == 0) begin
         check("unexpected_frame", 32'(bits), 0);
      end else begin
         logic [9:0] want;
         want = exp_frame_q.pop_front();
         check($sformatf("frame_%03h", want), 32'(bits), 32'(want));
      end
      dev_bit  = -1;
      dev_busy = 1'b0;
   endtask

   // Device model: measures each inhibit, then clocks a frame unless told to stay silent.
   initial forever begin
      @(negedge clk);
      if (ps2c_pull_low === 1'b1) begin
         dev_low_cnt  = 0;
         dev_both_cnt = 0;
         while (ps2c_pull_low === 1'b1) begin
            dev_low_cnt++;
            if (ps2d_pull_low === 1'b1) dev_both_cnt++;
            @(negedge clk);
         end
         inhibits_seen++;
         release_cyc = cyc;
         check("inhibit_len", dev_low_cnt, INH);
         check("start_overlap", dev_both_cnt, 1);
         if (dev_clocks) run_frame();
      end
   end

   // Outcome monitor: pops the scoreboard on every done/error pulse.
   initial forever begin
      @(negedge clk);
      if (tx_done === 1'b1 || tx_error === 1'b1) begin
         if (tx_done === 1'b1) done_seen++;
         if (exp_q.size() == 0) begin
            check("unexpected_outcome", {30'd0, tx_done, tx_error}, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("outcome_error", 32'(tx_error), 32'(mon_e.is_err));
            check("outcome_done", 32'(tx_done), 32'(!mon_e.is_err));
            check("ready_with_pulse", 32'(tx_ready), 1);
            if (mon_e.chk_to) begin
               check("timeout_latency", cyc - release_cyc, TO);
               check("timeout_pullc", 32'(ps2c_pull_low), 0);
               check("timeout_pulld", 32'(ps2d_pull_low), 0);
            end
         end
      end
   end

   task automatic push_exp(input logic is_err, input logic chk_to);
      exp_t e;
      e.is_err = is_err;
      e.chk_to = chk_to;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [7:0] d);
      int k;
      k        = 0;
      tx_data  = d;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && k < 20000) begin
         @(negedge clk);
         k++;
      end
      check("accept_ready", 32'(tx_ready), 1);
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = ~d;
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || exp_frame_q.size() != 0 || dev_busy || tx_ready !== 1'b1) &&
             k < budget) begin
         @(negedge clk);
         k++;
      end
      check("drain_outcomes", exp_q.size(), 0);
      check("drain_frames", exp_frame_q.size(), 0);
   endtask

   initial begin
      int k;
      int base_frames;
      int base_inh;
      int base_done;

      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(tx_ready), 1);
      check("rst_done", 32'(tx_done), 0);
      check("rst_error", 32'(tx_error), 0);
      check("rst_pullc", 32'(ps2c_pull_low), 0);
      check("rst_pulld", 32'(ps2d_pull_low), 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
      exp_frame_q.push_back(10'h3ED);
      push_exp(1'b0, 1'b0);
      send(8'hED);
      drain(20000);
      check("ready_after_ed", 32'(tx_ready), 1);
      check("ed_done_count", done_seen, 1);

      // 0xF4 has parity 0, 0xFF has parity 1
      exp_frame_q.push_back(10'h2F4);
      push_exp(1'b0, 1'b0);
      send(8'hF4);
      drain(20000);
      exp_frame_q.push_back(10'h3FF);
      push_exp(1'b0, 1'b0);
      send(8'hFF);
      drain(20000);

      // NACK: device leaves PS2D high on the ACK clock
      base_inh = inhibits_seen;
      dev_ack  = 1'b0;
      for (int a = 0; a < ATTEMPTS; a++) exp_frame_q.push_back(10'h300);
      push_exp(1'b1, 1'b0);
      send(8'h00);
      drain(20000);
      dev_ack = 1'b1;
      check("nack_attempts", inhibits_seen - base_inh, ATTEMPTS);

      // Device never clocks: timeout releases both lines and pulses tx_error
      base_inh   = inhibits_seen;
      dev_clocks = 1'b0;
      push_exp(1'b1, 1'b1);
      send(8'hED);
      drain(20000);
      dev_clocks = 1'b1;
      check("timeout_attempts", inhibits_seen - base_inh, ATTEMPTS);

      // Reset while d4 of 0xED is on the bus
      dev_skip = 1'b1;
      send(8'hED);
      k = 0;
      while (dev_bit != 4 && k < 20000) begin
         @(negedge clk);
         k++;
      end
      check("reached_bit4", dev_bit, 4);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_pullc", 32'(ps2c_pull_low), 0);
      check("midrst_pulld", 32'(ps2d_pull_low), 0);
      check("midrst_ready", 32'(tx_ready), 1);
      check("midrst_done", 32'(tx_done), 0);
      check("midrst_error", 32'(tx_error), 0);
      reset = 1'b0;
      k = 0;
      while (dev_busy && k < 20000) begin
         @(negedge clk);
         k++;
      end
      check("device_idle", 32'(dev_busy), 0);
      exp_frame_q.push_back(10'h3FF);
      push_exp(1'b0, 1'b0);
      send(8'hFF);
      drain(20000);

      // tx_valid held high with 0xAA while 0xED is in flight
      base_frames = frames_seen;
      base_inh    = inhibits_seen;
      base_done   = done_seen;
      exp_frame_q.push_back(10'h3ED);
      exp_frame_q.push_back(10'h3AA);
      push_exp(1'b0, 1'b0);
      push_exp(1'b0, 1'b0);
      tx_data  = 8'hED;
      tx_valid = 1'b1;
      @(negedge clk);
      check("ed_accepted", 32'(tx_ready), 0);
      tx_data = 8'hAA;
      k = 0;
      while (tx_ready !== 1'b1 && k < 20000) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      check("aa_accepted", 32'(tx_ready), 0);
      check("aa_after_ed_done", done_seen - base_done, 1);
      check("aa_after_ed_frame", frames_seen - base_frames, 1);
      tx_valid = 1'b0;
      drain(20000);
      check("two_frames", frames_seen - base_frames, 2);
      check("two_inhibits", inhibits_seen - base_inh, 2);

      repeat (10) @(negedge clk);
      check("total_done", done_seen, 6);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
